// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner with built-in refresh prescaler, per-frame data snapshot,
// per-digit decimal point and leading-zero blanking. Optional PWM dimming: SEG7_BRIGHTNESS_EN.
module seg7_scan_driver #(
   parameter int N_DIGITS    = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [4*N_DIGITS-1:0] data_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  blank_lz,
`ifdef SEG7_BRIGHTNESS_EN
   input  logic [3:0]            brightness,
`endif
   output logic [6:0]            segments,
   output logic                  dp,
   output logic [7:0]            anodos,
   output logic                  frame_start
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

   logic [PRE_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*N_DIGITS-1:0] shadow_data_q, shadow_data_d;
   logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [7:0]            anodos_q, anodos_d;
   logic [6:0]            segments_q, segments_d;
   logic                  dp_q, dp_d;
   logic                  frame_start_q, frame_start_d;

   logic [3:0]            nib [N_DIGITS];
   logic [N_DIGITS-1:0]   nz_from;
   logic [N_DIGITS-1:0]   lz_blank;

   // nz_from[i] is set when any nibble at position i or above is non-zero
   genvar gi;
   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         assign nib[gi] = shadow_data_q[4*gi +: 4];
         if (gi == N_DIGITS - 1) begin : g_top
            assign nz_from[gi] = |nib[gi];
         end else begin : g_mid
            assign nz_from[gi] = (|nib[gi]) | nz_from[gi+1];
         end
         if (gi == 0) begin : g_first
            assign lz_blank[gi] = 1'b0;
         end else begin : g_rest
            assign lz_blank[gi] = ~nz_from[gi];
         end
      end
   endgenerate

   function automatic logic [6:0] hex_font(input logic [3:0] v);
      case (v)
         4'h0: hex_font = 7'b0000001;
         4'h1: hex_font = 7'b1001111;
         4'h2: hex_font = 7'b0010010;
         4'h3: hex_font = 7'b0000110;
         4'h4: hex_font = 7'b1001100;
         4'h5: hex_font = 7'b0100100;
         4'h6: hex_font = 7'b0100000;
         4'h7: hex_font = 7'b0001111;
         4'h8: hex_font = 7'b0000000;
         4'h9: hex_font = 7'b0000100;
         4'hA: hex_font = 7'b0001000;
         4'hB: hex_font = 7'b1100000;
         4'hC: hex_font = 7'b0110001;
         4'hD: hex_font = 7'b1000010;
         4'hE: hex_font = 7'b0110000;
         default: hex_font = 7'b0111000;
      endcase
   endfunction

`ifdef SEG7_BRIGHTNESS_EN
   logic [3:0]  bright_q, bright_d;
   logic [31:0] duty_lim;
   logic        lit;
   assign duty_lim = ((32'(bright_q) + 32'd1) * 32'(REFRESH_DIV)) / 32'd16;
   assign lit      = 32'(presc_q) < duty_lim;
`endif

   // Scan sequencing and snapshot; the snapshot tracks the inputs while disabled
   always_comb begin
      presc_d       = presc_q;
      idx_d         = idx_q;
      shadow_data_d = shadow_data_q;
      shadow_dp_d   = shadow_dp_q;
      frame_start_d = 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
      bright_d      = bright_q;
`endif
      if (!enable) begin
         presc_d       = '0;
         idx_d         = '0;
         shadow_data_d = data_in;
         shadow_dp_d   = dp_in;
`ifdef SEG7_BRIGHTNESS_EN
         bright_d      = brightness;
`endif
      end else if (presc_q == PRE_LAST) begin
         presc_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d         = '0;
            shadow_data_d = data_in;
            shadow_dp_d   = dp_in;
            frame_start_d = 1'b1;
`ifdef SEG7_BRIGHTNESS_EN
            bright_d      = brightness;
`endif
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   // Pin drive for the digit currently selected
   always_comb begin
      anodos_d   = 8'hFF;
      segments_d = 7'h7F;
      dp_d       = 1'b1;
      if (enable) begin
         anodos_d   = ~(8'd1 << idx_q);
         segments_d = (blank_lz && lz_blank[idx_q]) ? 7'h7F : hex_font(nib[idx_q]);
         dp_d       = ~shadow_dp_q[idx_q];
`ifdef SEG7_BRIGHTNESS_EN
         if (!lit) anodos_d = 8'hFF;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q       <= '0;
         idx_q         <= '0;
         shadow_data_q <= '0;
         shadow_dp_q   <= '0;
         anodos_q      <= 8'hFF;
         segments_q    <= 7'h7F;
         dp_q          <= 1'b1;
         frame_start_q <= 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
         bright_q      <= '0;
`endif
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         shadow_data_q <= shadow_data_d;
         shadow_dp_q   <= shadow_dp_d;
         anodos_q      <= anodos_d;
         segments_q    <= segments_d;
         dp_q          <= dp_d;
         frame_start_q <= frame_start_d;
`ifdef SEG7_BRIGHTNESS_EN
         bright_q      <= bright_d;
`endif
      end
   end

   assign anodos      = anodos_q;
   assign segments    = segments_q;
   assign dp          = dp_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (N_DIGITS=4, REFRESH_DIV=4): vector table plus scoreboard queue
// of expected per-cycle pin states {anodos, segments, dp, frame_start}.
module tb_seg7_scan_driver;

   localparam int N   = 4;
   localparam int DIV = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic [15:0]   data_in;
   logic [3:0]    dp_in;
   logic          blank_lz;
   logic [6:0]    segments;
   logic          dp;
   logic [7:0]    anodos;
   logic          frame_start;
`ifdef SEG7_BRIGHTNESS_EN
   logic [3:0]    brightness = 4'hF;
`endif

   seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .data_in     (data_in),
      .dp_in       (dp_in),
      .blank_lz    (blank_lz),
`ifdef SEG7_BRIGHTNESS_EN
      .brightness  (brightness),
`endif
      .segments    (segments),
      .dp          (dp),
      .anodos      (anodos),
      .frame_start (frame_start)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dpv;
      logic        blz;
      logic [27:0] seg;   // expected segments {d3,d2,d1,d0}
   } vec_t;

   typedef logic [16:0] obs_t;   // {anodos, segments, dp, frame_start}
   localparam obs_t DARK = {8'hFF, 7'h7F, 1'b1, 1'b0};

   obs_t  exp_q [$];
   obs_t  mon_e, mon_g;
   string tag = "reset";
   int    slot_no = 0;
   int    checks = 0;
   int    errors = 0;
   vec_t  tbl [7];

   function automatic obs_t slot(vec_t v, int d, logic fs);
      logic [7:0] an;
      an    = 8'hFF;
      an[d] = 1'b0;
      return {an, v.seg[7*d +: 7], ~v.dpv[d], fs};
   endfunction

   task automatic push_frame(vec_t v);
      for (int d = 0; d < N; d++)
         for (int k = 0; k < DIV; k++)
            exp_q.push_back(slot(v, d, (d == N-1) && (k == DIV-1)));
   endtask

   task automatic wait_drain(int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(posedge clock);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: %0d expected slots never observed, required 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Blank for one cycle with the new inputs, then enable; first scanned slot follows E0
   task automatic start_scan(vec_t v, string t);
      @(posedge clock); #1;
      enable = 1'b0; data_in = v.data; dp_in = v.dpv; blank_lz = v.blz;
      tag = t; slot_no = 0;
      @(posedge clock); #1;
      exp_q.push_back(DARK);
      enable = 1'b1;
      @(posedge clock); #1;
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_g = {anodos, segments, dp, frame_start};
         checks++;
         if (mon_g !== mon_e) begin
            errors++;
            $display("FAIL %s slot%0d: got an=%h seg=%b dp=%b fs=%b, required an=%h seg=%b dp=%b fs=%b",
                     tag, slot_no, mon_g[16:9], mon_g[8:2], mon_g[1], mon_g[0],
                     mon_e[16:9], mon_e[8:2], mon_e[1], mon_e[0]);
         end
         slot_no++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t va, vb;
      tbl[0] = '{16'h1234, 4'b0000, 1'b0, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
      tbl[1] = '{16'h0050, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'b0100100, 7'b0000001}};
      tbl[2] = '{16'hABCD, 4'b0101, 1'b0, {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}};
      tbl[3] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b0000001}};
      tbl[4] = '{16'h0E8F, 4'b0010, 1'b1, {7'h7F, 7'b0110000, 7'b0000000, 7'b0111000}};
      tbl[5] = '{16'h0000, 4'b0000, 1'b0, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};
      tbl[6] = '{16'h9076, 4'b1111, 1'b1, {7'b0000100, 7'b0000001, 7'b0001111, 7'b0100000}};

      // Reset held 3 cycles with live inputs, then one quiet cycle after release
      reset = 1'b1; enable = 1'b1; data_in = 16'h1234; dp_in = 4'hF; blank_lz = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         exp_q.push_back(DARK);
      end
      reset = 1'b0; enable = 1'b0;
      @(posedge clock); #1;
      exp_q.push_back(DARK);
      wait_drain(10);
      $display("txn reset: checked, errors so far %0d", errors);

      for (int i = 0; i < 7; i++) begin
         start_scan(tbl[i], $sformatf("vec%0d", i));
         push_frame(tbl[i]);
         wait_drain(40);
         $display("txn vec%0d data=%h dp=%b blz=%b: errors so far %0d",
                  i, tbl[i].data, tbl[i].dpv, tbl[i].blz, errors);
      end

      // Mid-frame data change stays hidden until the next frame
      va = tbl[0];
      vb = '{16'hABCD, 4'b0000, 1'b0, tbl[2].seg};
      start_scan(va, "midframe");
      push_frame(va);
      push_frame(vb);
      repeat (8) @(posedge clock);
      #1 data_in = 16'hABCD;
      wait_drain(60);
      $display("txn midframe: errors so far %0d", errors);

      // Enable dropped at index 2, re-raised one cycle later: restart at digit 0, no frame_start
      start_scan(va, "enable_drop");
      for (int s = 0; s < 9; s++) exp_q.push_back(slot(va, s / DIV, 1'b0));
      exp_q.push_back(DARK);
      for (int s = 0; s < 8; s++) exp_q.push_back(slot(va, s / DIV, 1'b0));
      repeat (8) @(posedge clock);
      #1 enable = 1'b0;
      @(posedge clock);
      #1 enable = 1'b1;
      wait_drain(40);
      $display("txn enable_drop: errors so far %0d", errors);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multiplexed 7-segment display scanner for the Nexys-class 8-digit board display.
- Generalises the fixed 8-digit hex driver with:
  - a configurable digit count;
  - a built-in refresh prescaler, so no external slow clock is needed;
  - frame-synchronous data snapshot (no tearing);
  - per-digit decimal point;
  - optional leading-zero blanking;
  - a global display enable.
- Sits between the datapath (ALU result, counters) and the board's anode and cathode pins.

Parameters:
- N_DIGITS, default 8: number of scanned digits. Legal range 1..8. Data width is 4*N_DIGITS.
- REFRESH_DIV, default 100000: clock cycles each digit stays lit. Legal range ≥ 2. For the optional feature it must be a multiple of 16.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: 1 = scan the display; 0 = all digits dark.
- data_in, input, 4*N_DIGITS: hex nibbles. Digit 0 = bits [3:0].
- dp_in, input, N_DIGITS: decimal point request per digit, active-high.
- blank_lz, input, 1: 1 = suppress leading zeros.
- segments, output, 7: {CA,CB,CC,CD,CE,CF,CG}, active-low.
- dp, output, 1: decimal point cathode, active-low.
- anodos, output, 8: {AN7..AN0}, active-low, one-cold.
- frame_start, output, 1: one-cycle pulse when digit 0 begins a new frame.

Behaviour:
- Reset (synchronous, active-high, on clock):
  - prescaler = 0, digit index = 0;
  - shadow data = 0, shadow dp = 0;
  - anodos = 8'hFF, segments = 7'h7F, dp = 1, frame_start = 0.
- Prescaler:
  - counts 0..REFRESH_DIV-1 and wraps;
  - on the terminal count, the digit index advances by 1 and wraps N_DIGITS-1 → 0.
- Snapshot:
  - shadow data and shadow dp are loaded from data_in / dp_in on the cycle the index wraps to 0;
  - they are also loaded on every cycle while enable = 0;
  - data changes mid-frame are invisible until the next frame.
- frame_start pulses in the cycle the index becomes 0 via wrap.
- Decode:
  - selected shadow nibble → standard hex font, active-low;
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 8 = 0000000, A = 0001000, E = 0110000, F = 0111000.
- Leading-zero blanking (blank_lz = 1):
  - digit i > 0 is blank when shadow nibbles i..N_DIGITS-1 are all zero;
  - a blank digit has segments = 7'h7F and its anode is still strobed;
  - digit 0 is never blanked;
  - dp is unaffected by blanking.
- Output timing:
  - all outputs are registered, with 1 cycle latency from the index change;
  - anodos bit = 0 only for the current index;
  - bits N_DIGITS..7 are constantly 1.
- enable = 0:
  - prescaler and index are held at 0;
  - next cycle: anodos = 8'hFF, segments = 7'h7F, dp = 1.
- enable rising:
  - scanning restarts at digit 0 with a freshly loaded snapshot;
  - frame_start is not pulsed for this restart.
- Reset mid-frame has priority over everything and returns the block to the reset state in the next cycle.
- N_DIGITS = 1: the index stays at 0; frame_start pulses every REFRESH_DIV cycles.

Optional Feature:
- Macro: SEG7_BRIGHTNESS_EN.
- Defined:
  - adds input port brightness [3:0];
  - within each digit slot the anode is driven low only while prescaler < ((brightness+1)*REFRESH_DIV)/16;
  - segments and dp keep their values;
  - brightness = 15 gives full duty; brightness = 0 gives 1/16 duty;
  - brightness is sampled with the snapshot.
- Undefined: no brightness port; full duty cycle.

Test Plan (N_DIGITS = 4, REFRESH_DIV = 4 unless stated):
1. Assert reset for 3 cycles → anodos = FF, segments = 7F, dp = 1, frame_start = 0. Remain there one cycle after release.
2. enable = 1, data_in = 16'h1234, blank_lz = 0 → anodos cycles FE, FD, FB, F7, each held 4 cycles; segments = 1001100, 0000110, 0010010, 1001111 respectively; frame_start every 16 cycles.
3. data_in = 16'h0050, blank_lz = 1, dp_in = 4'b1000 → digits 3 and 2: segments = 7F; digit 3: dp = 0; digit 1 shows 5; digit 0 shows 0000001.
4. Change data_in from 16'h1234 to 16'hABCD while index = 2 → digits 2 and 3 still show 2 and 1. Next frame shows D, C, B, A.
5. Drop enable at index 2 → next cycle anodos = FF. Re-raise → anodos = FE one cycle later, holds 4 cycles, no frame_start pulse.
6. With SEG7_BRIGHTNESS_EN, REFRESH_DIV = 16, brightness = 3 → each anode is low for 4 of 16 cycles; brightness = 15 → low for all 16.
